// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer:
// T-state codes, class codes, bus IDs, bus field map.
package control_sequencer_pkg;

  localparam int CTRL_WIDTH = 33;
  localparam int DATA_WIDTH = 8;

  localparam logic [4:0] MID_MEM = 5'd4;
  localparam logic [4:0] SID_IR0 = 5'd0;
  localparam logic [4:0] SID_IR1 = 5'd1;
  localparam logic [4:0] ID_A    = 5'd2;
  localparam logic [4:0] MID_ALU = 5'd5;

  localparam int OFS_SID_EN = 0;
  localparam int OFS_MID_EN = 1;
  localparam int OFS_PC_INR = 2;
  localparam int OFS_AMID   = 3;
  localparam int OFS_SID    = 5;
  localparam int OFS_MID    = 10;
  localparam int OFS_ALU    = 15;

  localparam logic [2:0] CLS_NOP = 3'b000;
  localparam logic [2:0] CLS_LDA = 3'b001;
  localparam logic [2:0] CLS_STA = 3'b010;
  localparam logic [2:0] CLS_ALU = 3'b011;
  localparam logic [2:0] CLS_HLT = 3'b111;

  localparam logic [1:0] AMID_PC  = 2'd0;
  localparam logic [1:0] AMID_OPD = 2'd1;

  typedef enum logic [2:0] {
    ST_T0 = 3'd0,
    ST_T1 = 3'd1,
    ST_T2 = 3'd2,
    ST_T3 = 3'd3,
    ST_T4 = 3'd4,
    ST_D  = 3'd5,
    ST_E0 = 3'd6,
    ST_E1 = 3'd7
  } tstate_e;

  function automatic logic is_legal(
    input logic [2:0] cls
  );
    return (cls == CLS_NOP) || (cls == CLS_LDA) ||
           (cls == CLS_STA) || (cls == CLS_ALU) ||
           (cls == CLS_HLT);
  endfunction

  function automatic logic [CTRL_WIDTH-1:0] pack_bus(
    input logic [4:0] alu,
    input logic [4:0] mid,
    input logic [4:0] sid,
    input logic [1:0] amid,
    input logic       pc_inr,
    input logic       mid_en,
    input logic       sid_en
  );
    return {13'b0, alu, mid, sid, amid,
            pc_inr, mid_en, sid_en};
  endfunction

endpackage

// File: rtl/control_sequencer_tstate_counter.sv
// 3-bit falling-edge T-state counter with
// synchronous clear/hold and async active-low reset.
module tstate_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       hold_i,
  output logic [2:0] cnt_o
);

  logic [2:0] cnt_q;

  // clear wins over hold; otherwise count up
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else if (clr_i) begin
      cnt_q <= 3'd0;
    end else if (!hold_i) begin
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/control_sequencer.sv
// CPU control unit: fetch, decode, execute sequencing.
// Option macro: CTRL_SEQ_SINGLE_STEP_EN adds a step input.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ir0,
  input  logic [DATA_WIDTH-1:0] ir1,
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [CTRL_WIDTH-1:0] control_bus,
  output logic                  halt,
  output logic                  illegal_op
);

  // An instruction occupies the eight T-states
  // T0..T4, D, E0, E1. SID_EN drops as the next
  // T0 begins, so that edge is the release cycle.

  logic [2:0] cnt;
  tstate_e    st_q;
  tstate_e    st_d;
  logic       clr;
  logic       hold;
  logic       go;
  logic       halting;
  logic       live_q;
  logic       live_d;
  logic       halt_q;
  logic [2:0] cls_q;
  logic [4:0] op_q;
  logic       ill_q;
  logic [CTRL_WIDTH-1:0] bus_q;
  logic [CTRL_WIDTH-1:0] bus_d;

  logic [4:0] x_alu;
  logic [4:0] x_mid;
  logic [4:0] x_sid;
  logic [1:0] x_amid;
  logic       x_en;

  logic unused_ir1;
  assign unused_ir1 = ^ir1;

`ifdef CTRL_SEQ_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  tstate_counter u_tstate (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (clr),
    .hold_i (hold),
    .cnt_o  (cnt)
  );

  assign st_q = tstate_e'(cnt);

  // next T-state, run/halt decisions
  always_comb begin
    clr     = 1'b0;
    hold    = 1'b0;
    halting = 1'b0;
    live_d  = live_q;
    if (halt_q) begin
      hold = 1'b1;
    end else if (!live_q) begin
      hold   = 1'b1;
      live_d = go;
    end else begin
      unique case (st_q)
        ST_D: begin
          if (cls_q == CLS_HLT) begin
            clr     = 1'b1;
            halting = 1'b1;
            live_d  = 1'b0;
          end
        end
        ST_E1: begin
          clr    = 1'b1;
          live_d = go;
        end
        default: ;
      endcase
    end
    if (clr) begin
      st_d = ST_T0;
    end else if (hold) begin
      st_d = st_q;
    end else begin
      st_d = tstate_e'(cnt + 3'd1);
    end
  end

  // execute fields for the latched class
  always_comb begin
    x_alu  = 5'd0;
    x_mid  = 5'd0;
    x_sid  = 5'd0;
    x_amid = AMID_PC;
    x_en   = 1'b0;
    unique case (1'b1)
      (cls_q == CLS_LDA): begin
        x_amid = AMID_OPD;
        x_mid  = MID_MEM;
        x_sid  = ID_A;
        x_en   = 1'b1;
      end
      (cls_q == CLS_STA): begin
        x_amid = AMID_OPD;
        x_mid  = ID_A;
        x_sid  = MID_MEM;
        x_en   = 1'b1;
      end
      (cls_q == CLS_ALU): begin
        x_amid = AMID_PC;
        x_mid  = MID_ALU;
        x_sid  = ID_A;
        x_alu  = op_q;
        x_en   = 1'b1;
      end
      default: ;
    endcase
  end

  // bus image for the state being entered
  always_comb begin
    bus_d = '0;
    if (live_d) begin
      unique case (st_d)
        ST_T0: bus_d = pack_bus(5'd0, MID_MEM,
          SID_IR0, AMID_PC, 1'b0, 1'b1, 1'b0);
        ST_T1: bus_d = pack_bus(5'd0, MID_MEM,
          SID_IR0, AMID_PC, 1'b1, 1'b1, 1'b1);
        ST_T2: bus_d = pack_bus(5'd0, MID_MEM,
          SID_IR0, AMID_PC, 1'b0, 1'b1, 1'b0);
        ST_T3: bus_d = pack_bus(5'd0, MID_MEM,
          SID_IR1, AMID_PC, 1'b1, 1'b1, 1'b1);
        ST_T4: bus_d = pack_bus(5'd0, MID_MEM,
          SID_IR1, AMID_PC, 1'b0, 1'b0, 1'b0);
        ST_D:  bus_d = '0;
        ST_E0: bus_d = pack_bus(x_alu, x_mid,
          x_sid, x_amid, 1'b0, x_en, 1'b0);
        ST_E1: bus_d = pack_bus(x_alu, x_mid,
          x_sid, x_amid, 1'b0, x_en, x_en);
        default: bus_d = '0;
      endcase
    end
  end

  // falling-edge registers: run flags, IR latch, outputs
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      live_q <= 1'b0;
      halt_q <= 1'b0;
      cls_q  <= CLS_NOP;
      op_q   <= 5'd0;
      ill_q  <= 1'b0;
      bus_q  <= '0;
    end else begin
      live_q <= live_d;
      halt_q <= halt_q | halting;
      if (live_d && (st_d == ST_D)) begin
        cls_q <= ir0[7:5];
        op_q  <= ir0[4:0];
      end
      ill_q <= live_d && (st_d == ST_D) &&
               !is_legal(ir0[7:5]);
      bus_q <= bus_d;
    end
  end

  assign control_bus = bus_q;
  assign halt        = halt_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer.
// Default build (single-step option off).
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  ir0;
  logic [7:0]  ir1;
  logic [32:0] control_bus;
  logic        halt;
  logic        illegal_op;

  int checks;
  int failures;

  control_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .ir0         (ir0),
    .ir1         (ir1),
    .control_bus (control_bus),
    .halt        (halt),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hand-computed fetch images T0..T4, D
  logic [32:0] fetch_exp [0:5];
  initial begin
    fetch_exp[0] = 33'h01002;
    fetch_exp[1] = 33'h01007;
    fetch_exp[2] = 33'h01002;
    fetch_exp[3] = 33'h01027;
    fetch_exp[4] = 33'h01020;
    fetch_exp[5] = 33'h00000;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // one full instruction; optional D-only poke
  // and optional reset pulse in E1
  task automatic run_instr(
    input string       nm,
    input logic [7:0]  op,
    input logic [7:0]  opd,
    input logic [32:0] e0,
    input logic [32:0] e1,
    input bit          ill,
    input bit          poke,
    input bit          rst_e1
  );
    logic [32:0] exp;
    ir0 = op;
    ir1 = opd;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (c < 6) exp = fetch_exp[c];
      else if (c == 6) exp = e0;
      else exp = e1;
      check($sformatf("%s_bus_c%0d", nm, c),
            64'(control_bus), 64'(exp));
      check($sformatf("%s_ill_c%0d", nm, c),
            64'(illegal_op),
            64'((c == 5) && ill));
      check($sformatf("%s_halt_c%0d", nm, c),
            64'(halt), 64'(0));
      if (poke && c == 6) ir0 = 8'h00;
      if (rst_e1 && c == 7) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s_rst_bus", nm),
              64'(control_bus), 64'(0));
        check($sformatf("%s_rst_ill", nm),
              64'(illegal_op), 64'(0));
        #2;
        reset = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    ir0      = 8'h00;
    ir1      = 8'h00;
    #15;
    check("rst_bus", 64'(control_bus), 64'(0));
    check("rst_halt", 64'(halt), 64'(0));
    check("rst_ill", 64'(illegal_op), 64'(0));
    #8;
    reset = 1'b1;
    @(negedge clk);

    run_instr("lda", 8'h20, 8'h05,
              33'h0104A, 33'h0104B, 0, 0, 0);
    run_instr("alu", 8'h6A, 8'h00,
              33'h51442, 33'h51443, 0, 1, 0);
    run_instr("nop", 8'h00, 8'h00,
              33'h0, 33'h0, 0, 0, 0);
    run_instr("ill", 8'h80, 8'h00,
              33'h0, 33'h0, 1, 0, 0);
    run_instr("sta", 8'h40, 8'h10,
              33'h0088A, 33'h0088B, 0, 0, 1);
    run_instr("lda2", 8'h3F, 8'h01,
              33'h0104A, 33'h0104B, 0, 0, 0);

    ir0 = 8'hE0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hlt_bus_c%0d", c),
            64'(control_bus), 64'(fetch_exp[c]));
      check($sformatf("hlt_halt_c%0d", c),
            64'(halt), 64'(0));
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hlt_idle_bus_%0d", c),
            64'(control_bus), 64'(0));
      check($sformatf("hlt_idle_halt_%0d", c),
            64'(halt), 64'(1));
      if (c == 3) ir0 = 8'h20;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
